// File: rtl/ex_pkg.sv
// Shared encodings for the EX stage: ALU op codes, multiply/divide op codes and MDU state.
package ex_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned ALU_W        = 4;
  localparam int unsigned MD_W         = 3;

  localparam logic [ALU_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_W-1:0] ALU_NOR  = 4'd5;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'd6;
  localparam logic [ALU_W-1:0] ALU_SLTU = 4'd7;
  localparam logic [ALU_W-1:0] ALU_SLL  = 4'd8;
  localparam logic [ALU_W-1:0] ALU_SRL  = 4'd9;
  localparam logic [ALU_W-1:0] ALU_SRA  = 4'd10;
  localparam logic [ALU_W-1:0] ALU_LUI  = 4'd11;

  localparam logic [MD_W-1:0] MD_NONE  = 3'd0;
  localparam logic [MD_W-1:0] MD_MULT  = 3'd1;
  localparam logic [MD_W-1:0] MD_MULTU = 3'd2;
  localparam logic [MD_W-1:0] MD_DIV   = 3'd3;
  localparam logic [MD_W-1:0] MD_DIVU  = 3'd4;
  localparam logic [MD_W-1:0] MD_MFHI  = 3'd5;
  localparam logic [MD_W-1:0] MD_MFLO  = 3'd6;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply (shift-add) / divide (restoring) unit: one step per cycle, XLEN steps.
module muldiv_unit import ex_pkg::*; #(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [MD_W-1:0] op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  mdu_state_e       state;
  logic [CNT_W-1:0] count;
  logic [XLEN:0]    acc_hi;
  logic [XLEN-1:0]  acc_lo;
  logic [XLEN-1:0]  opnd;
  logic             is_div, neg_q, neg_r, div0;

  logic            signed_op, a_neg, b_neg, start_div;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum, shifted, diff, step_hi;
  logic [XLEN-1:0] step_lo, res_hi, res_lo;
  logic [2*XLEN-1:0] prod;

  // Signed ops run on magnitudes; signs are reapplied when the result is written.
  always_comb begin
    signed_op = (op == MD_MULT) || (op == MD_DIV);
    start_div = (op == MD_DIV) || (op == MD_DIVU);
    a_neg     = signed_op && a[XLEN-1];
    b_neg     = signed_op && b[XLEN-1];
    a_mag     = a_neg ? XLEN'(-a) : a;
    b_mag     = b_neg ? XLEN'(-b) : b;
  end

  always_comb begin
    mul_sum = acc_hi + (acc_lo[0] ? {1'b0, opnd} : '0);
    shifted = {acc_hi[XLEN-1:0], acc_lo[XLEN-1]};
    diff    = shifted - {1'b0, opnd};
    if (is_div) begin
      step_hi = diff[XLEN] ? shifted : diff;
      step_lo = {acc_lo[XLEN-2:0], ~diff[XLEN]};
    end else begin
      {step_hi, step_lo} = (2*XLEN+1)'({mul_sum, acc_lo} >> 1);
    end
    prod   = {step_hi[XLEN-1:0], step_lo};
    res_hi = '0;
    res_lo = '0;
    if (is_div) begin
      res_lo = div0 ? '1 : (neg_q ? XLEN'(-step_lo) : step_lo);
      res_hi = neg_r ? XLEN'(-step_hi[XLEN-1:0]) : step_hi[XLEN-1:0];
    end else begin
      if (neg_q) prod = (2*XLEN)'(-prod);
      {res_hi, res_lo} = prod;
    end
  end

  assign busy = (state == MDU_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MDU_IDLE;
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (start) begin
            state  <= MDU_BUSY;
            count  <= CNT_W'(XLEN-1);
            is_div <= start_div;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            div0   <= (b == '0);
            acc_hi <= '0;
            acc_lo <= start_div ? a_mag : b_mag;
            opnd   <= start_div ? b_mag : a_mag;
          end
        end
        MDU_BUSY: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          if (count == '0) begin
            hi    <= res_hi;
            lo    <= res_lo;
            state <= MDU_IDLE;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_muldiv_stage.sv
// EX pipeline stage: operand forwarding, ALU, MDU issue/stall control and the EX/MEM register.
module ex_muldiv_stage import ex_pkg::*; #(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned RA_W       = 5,
  parameter int unsigned MEM_CTRL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_ex_valid,
  input  logic [RA_W-1:0]       id_ex_rs,
  input  logic [RA_W-1:0]       id_ex_rt,
  input  logic [RA_W-1:0]       id_ex_rd,
  input  logic [XLEN-1:0]       id_ex_imm,
  input  logic [4:0]            id_ex_shamt,
  input  logic [XLEN-1:0]       id_ex_reg_a_data,
  input  logic [XLEN-1:0]       id_ex_reg_b_data,
  input  logic [ALU_W-1:0]      id_ex_alu_ctrl,
  input  logic                  id_ex_alu_src,
  input  logic                  id_ex_shift_shamt,
  input  logic                  id_ex_reg_dst,
  input  logic                  id_ex_reg_write,
  input  logic [MD_W-1:0]       id_ex_md_op,
  input  logic [MEM_CTRL_W-1:0] id_ex_mem_ctrl,
  input  logic                  flush_ex,
  input  logic [XLEN-1:0]       mem_wb_data,
  input  logic [RA_W-1:0]       mem_wb_rd,
  input  logic                  mem_wb_reg_write,
  output logic                  ex_stall,
  output logic                  ex_mem_valid,
  output logic                  ex_mem_reg_write,
  output logic [XLEN-1:0]       ex_mem_alu_out,
  output logic [XLEN-1:0]       ex_mem_reg_b_data,
  output logic [RA_W-1:0]       ex_mem_rd,
  output logic [MEM_CTRL_W-1:0] ex_mem_mem_ctrl
);

  localparam int unsigned SH_W = $clog2(XLEN);

  logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b, alu_y, result, md_hi, md_lo;
  logic            md_start_op, md_any_op, md_busy, md_start, bubble;

  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [RA_W-1:0] src,
    input logic [XLEN-1:0] reg_data,
    input logic            exm_we,
    input logic [RA_W-1:0] exm_rd,
    input logic [XLEN-1:0] exm_data,
    input logic            wb_we,
    input logic [RA_W-1:0] wb_rd,
    input logic [XLEN-1:0] wb_data
  );
    if (src != '0 && exm_we && exm_rd == src) return exm_data;
    if (src != '0 && wb_we && wb_rd == src)   return wb_data;
    return reg_data;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(id_ex_rs, id_ex_reg_a_data, ex_mem_reg_write, ex_mem_rd, ex_mem_alu_out,
                    mem_wb_reg_write, mem_wb_rd, mem_wb_data);
    fwd_b = fwd_sel(id_ex_rt, id_ex_reg_b_data, ex_mem_reg_write, ex_mem_rd, ex_mem_alu_out,
                    mem_wb_reg_write, mem_wb_rd, mem_wb_data);
    op_a  = id_ex_shift_shamt ? XLEN'(id_ex_shamt) : fwd_a;
    op_b  = id_ex_alu_src ? id_ex_imm : fwd_b;
  end

  // Shifts move operand B by operand A; ADD/SUB wrap without trapping.
  always_comb begin
    alu_y = '0;
    case (id_ex_alu_ctrl)
      ALU_ADD:  alu_y = op_a + op_b;
      ALU_SUB:  alu_y = op_a - op_b;
      ALU_AND:  alu_y = op_a & op_b;
      ALU_OR:   alu_y = op_a | op_b;
      ALU_XOR:  alu_y = op_a ^ op_b;
      ALU_NOR:  alu_y = ~(op_a | op_b);
      ALU_SLT:  alu_y = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU: alu_y = XLEN'(op_a < op_b);
      ALU_SLL:  alu_y = op_b << op_a[SH_W-1:0];
      ALU_SRL:  alu_y = op_b >> op_a[SH_W-1:0];
      ALU_SRA:  alu_y = XLEN'($signed(op_b) >>> op_a[SH_W-1:0]);
      ALU_LUI:  alu_y = op_b << 16;
      default:  alu_y = '0;
    endcase
  end

  always_comb begin
    md_start_op = (id_ex_md_op >= MD_MULT) && (id_ex_md_op <= MD_DIVU);
    md_any_op   = (id_ex_md_op >= MD_MULT) && (id_ex_md_op <= MD_MFLO);
    ex_stall    = id_ex_valid && md_any_op && md_busy && !flush_ex && !rst;
    md_start    = id_ex_valid && md_start_op && !md_busy && !flush_ex && !rst;
    bubble      = !id_ex_valid || flush_ex || ex_stall || md_start_op;
    result      = (id_ex_md_op == MD_MFHI) ? md_hi :
                  (id_ex_md_op == MD_MFLO) ? md_lo : alu_y;
  end

  muldiv_unit #(.XLEN(XLEN)) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .op    (id_ex_md_op),
    .a     (fwd_a),
    .b     (fwd_b),
    .busy  (md_busy),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ex_mem_valid      <= 1'b0;
      ex_mem_reg_write  <= 1'b0;
      ex_mem_alu_out    <= '0;
      ex_mem_reg_b_data <= '0;
      ex_mem_rd         <= '0;
      ex_mem_mem_ctrl   <= '0;
    end else begin
      ex_mem_valid      <= 1'b1;
      ex_mem_reg_write  <= id_ex_reg_write;
      ex_mem_alu_out    <= result;
      ex_mem_reg_b_data <= fwd_b;
      ex_mem_rd         <= id_ex_reg_dst ? id_ex_rd : id_ex_rt;
      ex_mem_mem_ctrl   <= id_ex_mem_ctrl;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Scoreboard bench for ex_muldiv_stage: directed scenarios plus a random instruction stream.
module tb_ex_muldiv_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_ex_valid;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd, id_ex_shamt;
  logic [31:0] id_ex_imm, id_ex_reg_a_data, id_ex_reg_b_data;
  logic [3:0]  id_ex_alu_ctrl;
  logic        id_ex_alu_src, id_ex_shift_shamt, id_ex_reg_dst, id_ex_reg_write;
  logic [2:0]  id_ex_md_op;
  logic [7:0]  id_ex_mem_ctrl;
  logic        flush_ex;
  logic [31:0] mem_wb_data;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_reg_write;
  logic        ex_stall, ex_mem_valid, ex_mem_reg_write;
  logic [31:0] ex_mem_alu_out, ex_mem_reg_b_data;
  logic [4:0]  ex_mem_rd;
  logic [7:0]  ex_mem_mem_ctrl;

  always #5 clk = ~clk;

  ex_muldiv_stage dut (
    .clk(clk), .rst(rst), .id_ex_valid(id_ex_valid),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .id_ex_imm(id_ex_imm), .id_ex_shamt(id_ex_shamt),
    .id_ex_reg_a_data(id_ex_reg_a_data), .id_ex_reg_b_data(id_ex_reg_b_data),
    .id_ex_alu_ctrl(id_ex_alu_ctrl), .id_ex_alu_src(id_ex_alu_src),
    .id_ex_shift_shamt(id_ex_shift_shamt), .id_ex_reg_dst(id_ex_reg_dst),
    .id_ex_reg_write(id_ex_reg_write), .id_ex_md_op(id_ex_md_op),
    .id_ex_mem_ctrl(id_ex_mem_ctrl), .flush_ex(flush_ex),
    .mem_wb_data(mem_wb_data), .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
    .ex_stall(ex_stall), .ex_mem_valid(ex_mem_valid), .ex_mem_reg_write(ex_mem_reg_write),
    .ex_mem_alu_out(ex_mem_alu_out), .ex_mem_reg_b_data(ex_mem_reg_b_data),
    .ex_mem_rd(ex_mem_rd), .ex_mem_mem_ctrl(ex_mem_mem_ctrl)
  );

  typedef struct {
    logic valid, flush;
    logic [4:0] rs, rt, rd, shamt;
    logic [31:0] imm, a, b;
    logic [3:0] alu;
    logic alu_src, shift_shamt, reg_dst, reg_write;
    logic [2:0] md;
    logic [7:0] mctrl;
    logic [31:0] wb_data;
    logic [4:0] wb_rd;
    logic wb_we;
  } instr_t;

  typedef struct packed {
    logic [31:0] val;
    logic [31:0] rb;
    logic [4:0]  rd;
    logic        we;
    logic [7:0]  mc;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Architectural model: last EX/MEM result, HI/LO, and cycles left on the running MDU op.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0, m_val = '0;
  logic        m_we = 1'b0;
  logic [4:0]  m_rd = '0;
  int          busy_left = 0;

  function automatic void chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return b << a[4:0];
      4'd9:  return b >> a[4:0];
      4'd10: return 32'($signed(b) >>> a[4:0]);
      4'd11: return {b[15:0], 16'h0};
      default: return 32'h0;
    endcase
  endfunction

  // Returns {HI, LO}.
  function automatic logic [63:0] mdu_ref(input logic [2:0] md, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int sa, sb;
    logic [63:0] u;
    sa = $signed(a);
    sb = $signed(b);
    case (md)
      3'd1: begin p = longint'(sa) * longint'(sb); return 64'(p); end
      3'd2: begin u = {32'h0, a} * {32'h0, b}; return u; end
      3'd3: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, a};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] fwd_ref(input logic [4:0] src, input logic [31:0] regv, input instr_t in);
    if (src != 5'd0 && m_we && m_rd == src) return m_val;
    if (src != 5'd0 && in.wb_we && in.wb_rd == src) return in.wb_data;
    return regv;
  endfunction

  function automatic instr_t nop();
    instr_t i;
    i = '{valid: 1'b0, flush: 1'b0, rs: 5'd0, rt: 5'd0, rd: 5'd0, shamt: 5'd0,
          imm: 32'h0, a: 32'h0, b: 32'h0, alu: 4'd0, alu_src: 1'b0, shift_shamt: 1'b0,
          reg_dst: 1'b1, reg_write: 1'b0, md: 3'd0, mctrl: 8'h0, wb_data: 32'h0,
          wb_rd: 5'd0, wb_we: 1'b0};
    return i;
  endfunction

  function automatic instr_t alu_i(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                   input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    instr_t i;
    i = nop();
    i.valid = 1'b1; i.alu = op; i.rs = rs; i.rt = rt; i.rd = rd;
    i.a = a; i.b = b; i.reg_write = 1'b1; i.mctrl = 8'($urandom);
    return i;
  endfunction

  function automatic instr_t md_i(input logic [2:0] md, input logic [31:0] a, input logic [31:0] b);
    instr_t i;
    i = alu_i(4'd0, 5'd0, 5'd0, 5'd9, a, b);
    i.md = md;
    i.reg_write = (md == 3'd5 || md == 3'd6);
    return i;
  endfunction

  task automatic step(input instr_t in, input logic r, output logic st);
    logic [31:0] fa, fb, oa, ob, val;
    logic md_start, bubble;
    logic [63:0] hl;
    rst = r; id_ex_valid = in.valid; flush_ex = in.flush;
    id_ex_rs = in.rs; id_ex_rt = in.rt; id_ex_rd = in.rd; id_ex_shamt = in.shamt;
    id_ex_imm = in.imm; id_ex_reg_a_data = in.a; id_ex_reg_b_data = in.b;
    id_ex_alu_ctrl = in.alu; id_ex_alu_src = in.alu_src; id_ex_shift_shamt = in.shift_shamt;
    id_ex_reg_dst = in.reg_dst; id_ex_reg_write = in.reg_write; id_ex_md_op = in.md;
    id_ex_mem_ctrl = in.mctrl; mem_wb_data = in.wb_data; mem_wb_rd = in.wb_rd;
    mem_wb_reg_write = in.wb_we;
    @(negedge clk);
    #1;
    st = !r && in.valid && !in.flush && busy_left > 0 && (in.md inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6});
    chk("ex_stall", 96'(ex_stall), 96'(st));
    if (r) begin
      busy_left = 0; m_hi = '0; m_lo = '0; m_we = 1'b0; m_rd = '0; m_val = '0;
    end else begin
      fa = fwd_ref(in.rs, in.a, in);
      fb = fwd_ref(in.rt, in.b, in);
      oa = in.shift_shamt ? {27'h0, in.shamt} : fa;
      ob = in.alu_src ? in.imm : fb;
      md_start = in.md inside {3'd1, 3'd2, 3'd3, 3'd4};
      bubble = !in.valid || in.flush || st || md_start;
      val = (in.md == 3'd5) ? m_hi : (in.md == 3'd6) ? m_lo : alu_ref(in.alu, oa, ob);
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
      end else if (in.valid && !in.flush && md_start) begin
        hl = mdu_ref(in.md, fa, fb);
        p_hi = hl[63:32]; p_lo = hl[31:0];
        busy_left = 32;
      end
      if (!bubble) begin
        q.push_back('{val: val, rb: fb, rd: in.reg_dst ? in.rd : in.rt, we: in.reg_write, mc: in.mctrl});
        m_we = in.reg_write; m_rd = in.reg_dst ? in.rd : in.rt; m_val = val;
      end else begin
        m_we = 1'b0; m_rd = '0; m_val = '0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Re-present an instruction while it is stalled, as a held ID/EX register would.
  task automatic issue(input instr_t in, output int stalls);
    logic st;
    stalls = 0;
    do begin
      step(in, 1'b0, st);
      if (st) stalls++;
    end while (st && stalls < 100);
    if (st) begin
      n_cmp++; n_bad++;
      $display("FAIL stall_timeout: still stalled after %0d cycles, required release", stalls);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ex_mem_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_output: alu_out %0h with no expected entry", ex_mem_alu_out);
      end else begin
        e = q.pop_front();
        chk("ex_mem_alu_out", 96'(ex_mem_alu_out), 96'(e.val));
        chk("ex_mem_fields", 96'({ex_mem_reg_b_data, ex_mem_rd, ex_mem_reg_write, ex_mem_mem_ctrl}),
            96'({e.rb, e.rd, e.we, e.mc}));
      end
    end else if (rst === 1'b0) begin
      chk("bubble_reg_write", 96'(ex_mem_reg_write), 96'(0));
    end
  end

  initial begin
    instr_t i;
    int s;
    logic st;
    step(nop(), 1'b1, st);
    step(nop(), 1'b1, st);
    chk("reset_outputs", 96'({ex_mem_valid, ex_mem_reg_write, ex_mem_alu_out, ex_mem_rd, ex_stall}), 96'(0));

    // Forwarding priority and register-0 exclusion.
    issue(alu_i(4'd0, 5'd1, 5'd0, 5'd3, 32'h10, 32'h0), s);
    i = alu_i(4'd0, 5'd3, 5'd0, 5'd5, 32'hDEAD, 32'h0);
    i.wb_we = 1'b1; i.wb_rd = 5'd3; i.wb_data = 32'h20;
    issue(i, s);
    chk("fwd_exmem_priority", 96'(ex_mem_alu_out), 96'(32'h10));
    issue(alu_i(4'd0, 5'd1, 5'd0, 5'd0, 32'h10, 32'h0), s);
    i = alu_i(4'd0, 5'd0, 5'd0, 5'd5, 32'hDEAD, 32'h0);
    i.wb_we = 1'b1; i.wb_rd = 5'd0; i.wb_data = 32'h20;
    issue(i, s);
    chk("fwd_r0_regdata", 96'(ex_mem_alu_out), 96'(32'hDEAD));

    // Multiply: MFLO right behind MULT stalls for the whole operation.
    issue(md_i(3'd1, 32'hFFFF_FFFF, 32'd2), s);
    issue(md_i(3'd6, 32'h0, 32'h0), s);
    chk("mflo_stall_cycles", 96'(s), 96'(32));
    chk("mult_lo", 96'(ex_mem_alu_out), 96'(32'hFFFF_FFFE));
    issue(md_i(3'd5, 32'h0, 32'h0), s);
    chk("mult_hi", 96'(ex_mem_alu_out), 96'(32'hFFFF_FFFF));
    issue(md_i(3'd2, 32'hFFFF_FFFF, 32'd2), s);
    issue(md_i(3'd5, 32'h0, 32'h0), s);
    chk("multu_hi", 96'(ex_mem_alu_out), 96'(32'h1));
    issue(md_i(3'd6, 32'h0, 32'h0), s);
    chk("multu_lo", 96'(ex_mem_alu_out), 96'(32'hFFFF_FFFE));

    // Divide: signed, by zero, and the MIN / -1 overflow case.
    issue(md_i(3'd3, 32'hFFFF_FFF9, 32'd2), s);
    issue(md_i(3'd6, 32'h0, 32'h0), s);
    chk("div_lo", 96'(ex_mem_alu_out), 96'(32'hFFFF_FFFD));
    issue(md_i(3'd5, 32'h0, 32'h0), s);
    chk("div_hi", 96'(ex_mem_alu_out), 96'(32'hFFFF_FFFF));
    issue(md_i(3'd4, 32'd5, 32'd0), s);
    issue(md_i(3'd6, 32'h0, 32'h0), s);
    chk("divu0_lo", 96'(ex_mem_alu_out), 96'(32'hFFFF_FFFF));
    issue(md_i(3'd5, 32'h0, 32'h0), s);
    chk("divu0_hi", 96'(ex_mem_alu_out), 96'(32'd5));
    issue(md_i(3'd3, 32'h8000_0000, 32'hFFFF_FFFF), s);
    issue(md_i(3'd6, 32'h0, 32'h0), s);
    chk("divmin_lo", 96'(ex_mem_alu_out), 96'(32'h8000_0000));
    issue(md_i(3'd5, 32'h0, 32'h0), s);
    chk("divmin_hi", 96'(ex_mem_alu_out), 96'(32'h0));

    // Flushed MULT never starts; flushed MFHI during BUSY leaves a bubble.
    i = md_i(3'd1, 32'd1000, 32'd1000); i.flush = 1'b1;
    issue(i, s);
    issue(md_i(3'd6, 32'h0, 32'h0), s);
    chk("flushed_mult_no_stall", 96'(s), 96'(0));
    chk("flushed_mult_lo_kept", 96'(ex_mem_alu_out), 96'(32'h8000_0000));
    issue(md_i(3'd1, 32'd3, 32'd3), s);
    i = md_i(3'd5, 32'h0, 32'h0); i.flush = 1'b1;
    step(i, 1'b0, st);
    chk("flushed_mfhi_bubble", 96'({ex_mem_valid, ex_stall}), 96'(0));
    // ALU traffic keeps flowing while the MDU is busy.
    for (int k = 0; k < 10; k++) begin
      issue(alu_i((k % 2 == 0) ? 4'd0 : 4'd3, 5'd0, 5'd0, 5'(k + 1), $urandom, $urandom), s);
      chk("busy_alu_flow", 96'({ex_mem_valid, 5'(s)}), 96'({1'b1, 5'd0}));
    end
    issue(md_i(3'd6, 32'h0, 32'h0), s);
    chk("mult3x3_lo", 96'(ex_mem_alu_out), 96'(32'd9));

    // Reset in the middle of an operation discards it.
    issue(md_i(3'd1, 32'd7, 32'd9), s);
    for (int k = 0; k < 21; k++) step(nop(), 1'b0, st);
    step(nop(), 1'b1, st);
    chk("rst_mid_busy_valid", 96'(ex_mem_valid), 96'(0));
    issue(md_i(3'd6, 32'h0, 32'h0), s);
    chk("rst_mid_busy_lo", 96'({ex_mem_alu_out, 8'(s)}), 96'(0));
    issue(md_i(3'd5, 32'h0, 32'h0), s);
    chk("rst_mid_busy_hi", 96'(ex_mem_alu_out), 96'(0));

    // Random stream with forwarding hazards, flushes and MDU traffic.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] picks [4];
      picks[0] = 32'h0; picks[1] = 32'hFFFF_FFFF; picks[2] = 32'h8000_0000; picks[3] = $urandom;
      i = alu_i(4'($urandom_range(0, 11)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), picks[$urandom_range(0, 3)], $urandom);
      if ($urandom_range(0, 3) == 0) i.b = picks[$urandom_range(0, 3)];
      i.valid = ($urandom_range(0, 9) != 0);
      i.flush = ($urandom_range(0, 9) == 0);
      i.imm = $urandom; i.shamt = 5'($urandom);
      i.alu_src = 1'($urandom); i.shift_shamt = 1'($urandom);
      i.reg_dst = 1'($urandom); i.reg_write = 1'($urandom);
      i.md = ($urandom_range(0, 9) < 6) ? 3'($urandom_range(0, 1) * 7) : 3'($urandom_range(1, 6));
      i.wb_we = 1'($urandom); i.wb_rd = 5'($urandom_range(0, 3)); i.wb_data = $urandom;
      issue(i, s);
    end
    for (int k = 0; k < 3; k++) step(nop(), 1'b0, st);
    chk("scoreboard_drained", 96'(q.size()), 96'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
